// File: rtl/pool_pkg.sv
// Shared definitions for the pooling scheduler slice.
//   DATA_WIDTH   - default sample / result width
//   NUM_REQ      - default number of requester channels
//   MAX_WIN_LOG2 - default log2 of the largest pooling window
//   pool_state_e - scheduler FSM states
//   pool_mode_e  - pooling operation (average or max)
package pool_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int NUM_REQ      = 4;
  localparam int MAX_WIN_LOG2 = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_COLLECT = 2'd2,
    ST_OUT     = 2'd3
  } pool_state_e;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_e;

  // Width of a requester index; never zero, even for a single channel.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_sched_if.sv
// Requester / result bus of the pooling scheduler.
//   req_valid / req_data / req_ready - per-requester sample stream,
//                                      channel i at req_data[i*DATA_WIDTH +: DATA_WIDTH]
//   res_valid / res_data / res_id / res_ready - pooled result stream
// master: the side that produces samples and consumes results.
// slave : the scheduler.
interface pool_sched_if #(
  parameter int NUM_REQ    = pool_pkg::NUM_REQ,
  parameter int DATA_WIDTH = pool_pkg::DATA_WIDTH,
  parameter int ID_W       = pool_pkg::id_width(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          res_valid;
  logic                          res_ready;
  logic [DATA_WIDTH-1:0]         res_data;
  logic [ID_W-1:0]               res_id;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_data, res_id
  );

endinterface

// File: rtl/pool_acc.sv
// Pooling accumulator datapath.
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - zero the accumulator at the start of a window
//   load_en    - fold `sample` into the accumulator this cycle
//   sample     - incoming sample
//   mode       - POOL_AVG sums, POOL_MAX keeps the running maximum
//   k          - log2 of the window size, used to scale the average
//   result     - max value, or sum >> k in average mode
module pool_acc #(
  parameter int DATA_WIDTH   = pool_pkg::DATA_WIDTH,
  parameter int MAX_WIN_LOG2 = pool_pkg::MAX_WIN_LOG2,
  parameter int K_W          = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      load_en,
  input  logic [DATA_WIDTH-1:0]     sample,
  input  pool_pkg::pool_mode_e      mode,
  input  logic [K_W-1:0]            k,
  output logic [DATA_WIDTH-1:0]     result
);
  import pool_pkg::*;

  // Wide enough to sum 2^MAX_WIN_LOG2 full-scale samples without wrapping.
  localparam int ACC_W = DATA_WIDTH + MAX_WIN_LOG2;

  logic [ACC_W-1:0] acc_q, acc_d;

  // In max mode the accumulator starts at zero after clear, so the first
  // sample always wins (or ties at zero): identical to loading it directly.
  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (load_en) begin
      if (mode == POOL_MAX) begin
        if (ACC_W'(sample) > acc_q) acc_d = ACC_W'(sample);
      end else begin
        acc_d = acc_q + ACC_W'(sample);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  always_comb begin
    result = DATA_WIDTH'(acc_q);
    if (mode == POOL_AVG) result = DATA_WIDTH'(acc_q >> k);
  end

endmodule

// File: rtl/pool_sched.sv
// Round-robin scheduler sharing one pooling datapath among requesters.
//   clk, rst_n    - clock, asynchronous active-low reset
//   cfg_mode      - 0 average, 1 max; captured when a requester is granted
//   cfg_win_log2  - window = 2^cfg_win_log2 samples (saturated); captured at grant
//   busy          - high whenever the FSM is not idle
//   bus (slave)   - per-requester sample streams and the pooled result stream
module pool_sched #(
  parameter int NUM_REQ      = pool_pkg::NUM_REQ,
  parameter int DATA_WIDTH   = pool_pkg::DATA_WIDTH,
  parameter int MAX_WIN_LOG2 = pool_pkg::MAX_WIN_LOG2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_mode,
  input  logic [2:0]   cfg_win_log2,
  output logic         busy,
  pool_sched_if.slave  bus
);
  import pool_pkg::*;

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = MAX_WIN_LOG2 + 1;

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] GRANT   = ST_GRANT;
  localparam logic [1:0] COLLECT = ST_COLLECT;
  localparam logic [1:0] OUT     = ST_OUT;

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  pool_mode_e       mode_q, mode_d;
  logic [2:0]       k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ID_W-1:0]       pick;
  logic                  any_req;
  logic                  accept;
  logic                  win_last;
  logic [CNT_W-1:0]      win_max;
  logic [DATA_WIDTH-1:0] sample;
  logic [DATA_WIDTH-1:0] acc_result;
  logic [2:0]            k_sat;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    int idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    pick    = last_grant_q;
    any_req = |bus.req_valid;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant_q) + off) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  assign sample   = bus.req_data[gnt_id_q*DATA_WIDTH +: DATA_WIDTH];
  assign accept   = (state_q == COLLECT) && bus.req_valid[gnt_id_q];
  assign win_max  = (CNT_W'(1) << k_q) - CNT_W'(1);
  assign win_last = (cnt_q == win_max);
  assign k_sat    = (cfg_win_log2 > 3'(MAX_WIN_LOG2)) ? 3'(MAX_WIN_LOG2) : cfg_win_log2;

  always_comb begin
    state_d      = state_q;
    gnt_id_d     = gnt_id_q;
    last_grant_d = last_grant_q;
    mode_d       = mode_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_id_d = pick;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        mode_d  = pool_mode_e'(cfg_mode);
        k_d     = k_sat;
        cnt_d   = '0;
        state_d = COLLECT;
      end
      COLLECT: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (win_last) state_d = OUT;
        end
      end
      OUT: begin
        if (bus.res_ready) begin
          last_grant_d = gnt_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_id_q     <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      mode_q       <= POOL_AVG;
      k_q          <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      gnt_id_q     <= gnt_id_d;
      last_grant_q <= last_grant_d;
      mode_q       <= mode_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
    end
  end

  pool_acc #(
    .DATA_WIDTH   (DATA_WIDTH),
    .MAX_WIN_LOG2 (MAX_WIN_LOG2),
    .K_W          (3)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == GRANT),
    .load_en (accept),
    .sample  (sample),
    .mode    (mode_q),
    .k       (k_q),
    .result  (acc_result)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign bus.req_ready[gi] = (state_q == COLLECT) && (gnt_id_q == ID_W'(gi));
  end

  // The accumulator is frozen in OUT, so the result holds until the handshake.
  assign bus.res_valid = (state_q == OUT);
  assign bus.res_data  = bus.res_valid ? acc_result : '0;
  assign bus.res_id    = gnt_id_q;
  assign busy          = (state_q != IDLE);

endmodule
